// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock level FIFO: read-mode constants and
// elaboration-time helpers for sizing and parameter legality.
package fifo_pkg;

   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int clog2(input int unsigned value);
      int result;
      int unsigned v;
      result = 0;
      v      = 1;
      while (v < value) begin
         v      = v << 1;
         result = result + 1;
      end
      return result;
   endfunction

   // Depth range is checked first so the shift below can never overflow.
   function automatic logic params_ok(input int addr_len, input int data_width,
                                      input int fwft, input int alm_full,
                                      input int alm_empty);
      int mem_size;
      if (addr_len < 2 || addr_len > 12) return 1'b0;
      mem_size = 1 << addr_len;
      return (data_width >= 1) &&
             (fwft == FIFO_MODE_REG || fwft == FIFO_MODE_FWFT) &&
             (alm_full >= 1) && (alm_full <= mem_size) &&
             (alm_empty >= 0) && (alm_empty <= mem_size - 1);
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one clock: one write port and one read port whose
// registered output holds its value while the read enable is low.
module sdp_ram #(
   parameter int W_A = 10,
   parameter int W_D = 32
) (
   input  logic           clk,
   input  logic           we,
   input  logic [W_A-1:0] waddr,
   input  logic [W_D-1:0] wdata,
   input  logic           re,
   input  logic [W_A-1:0] raddr,
   output logic [W_D-1:0] rdata
);

   logic [W_D-1:0] mem [1 << W_A];
   logic [W_D-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sync_level_fifo.sv
// Single-clock FIFO using every RAM slot, with fill level, programmable
// almost-full/almost-empty flags, sticky error flags and selectable FWFT read.
module sync_level_fifo
   import fifo_pkg::*;
#(
   parameter int ADDR_LEN         = 10,
   parameter int DATA_WIDTH       = 32,
   parameter int FWFT             = FIFO_MODE_REG,
   parameter int ALM_FULL_THRESH  = (1 << ADDR_LEN) - 4,
   parameter int ALM_EMPTY_THRESH = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  ENQ,
   output logic                  FULL,
   output logic                  ALM_FULL,
   output logic [DATA_WIDTH-1:0] Q,
   input  logic                  DEQ,
   output logic                  EMPTY,
   output logic                  ALM_EMPTY,
   output logic [ADDR_LEN:0]     LEVEL,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW,
   input  logic                  CLR_ERR
);

   localparam int MEM_SIZE = 1 << ADDR_LEN;
   localparam int PW       = clog2(MEM_SIZE + 1);
   localparam logic IS_FWFT = (FWFT == FIFO_MODE_FWFT);
   localparam logic [PW-1:0] FULL_LVL = PW'(MEM_SIZE);
   localparam logic [PW-1:0] AF_LVL   = PW'(ALM_FULL_THRESH);
   localparam logic [PW-1:0] AE_LVL   = PW'(ALM_EMPTY_THRESH);

   if (!params_ok(ADDR_LEN, DATA_WIDTH, FWFT, ALM_FULL_THRESH, ALM_EMPTY_THRESH)) begin : g_bad_params
      $error("sync_level_fifo: illegal parameter combination");
   end

   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
   logic          full_q, full_d, afull_q, afull_d;
   logic          empty_q, empty_d, aempty_q, aempty_d;
   logic          ovf_q, ovf_d, udf_q, udf_d;
   logic          valid_q, valid_d, shown_q, shown_d;
   logic          wr, rd, prefetch, ram_re;
   logic [DATA_WIDTH-1:0] ram_rdata;

   always_comb begin
      wr       = ENQ & ~full_q;
      rd       = DEQ & ~empty_q;
      // FWFT: refill the output register whenever it is free or being popped.
      prefetch = (~valid_q | rd) & (wptr_q != rptr_q);
      ram_re   = IS_FWFT ? prefetch : rd;

      wptr_d = wr     ? wptr_q + PW'(1) : wptr_q;
      rptr_d = ram_re ? rptr_q + PW'(1) : rptr_q;

      unique case ({wr, rd})
         2'b10:   level_d = level_q + PW'(1);
         2'b01:   level_d = level_q - PW'(1);
         default: level_d = level_q;
      endcase

      valid_d  = IS_FWFT & (prefetch | (valid_q & ~rd));
      full_d   = (level_d == FULL_LVL);
      afull_d  = (level_d >= AF_LVL);
      aempty_d = (level_d <= AE_LVL);
      empty_d  = IS_FWFT ? ~valid_d : (level_d == '0);
      shown_d  = shown_q | ram_re;

      // A new error in the same cycle takes priority over the clear.
      ovf_d = (ENQ & full_q)  | (ovf_q & ~CLR_ERR);
      udf_d = (DEQ & empty_q) | (udf_q & ~CLR_ERR);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         valid_q  <= 1'b0;
         shown_q  <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         valid_q  <= valid_d;
         shown_q  <= shown_d;
      end
   end

   sdp_ram #(
      .W_A (ADDR_LEN),
      .W_D (DATA_WIDTH)
   ) u_ram (
      .clk   (CLK),
      .we    (wr),
      .waddr (wptr_q[ADDR_LEN-1:0]),
      .wdata (D),
      .re    (ram_re),
      .raddr (rptr_q[ADDR_LEN-1:0]),
      .rdata (ram_rdata)
   );

   // RAM output is not reset; mask it until the first word has been loaded.
   assign Q         = shown_q ? ram_rdata : '0;
   assign FULL      = full_q;
   assign ALM_FULL  = afull_q;
   assign EMPTY     = empty_q;
   assign ALM_EMPTY = aempty_q;
   assign LEVEL     = level_q;
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_sync_level_fifo.sv
// Bench for sync_level_fifo: three configurations share one stimulus stream and
// are each compared against a word-list reference model after every edge.
module tb_sync_level_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, enq, deq, clr;
   logic [7:0] d;
   logic [7:0] q_o [3];
   logic       full_o [3], afull_o [3], empty_o [3], aempty_o [3], ovf_o [3], udf_o [3];
   logic [2:0] lvl0;
   logic [3:0] lvl1, lvl2;

   sync_level_fifo #(.ADDR_LEN(2), .DATA_WIDTH(8), .FWFT(0), .ALM_FULL_THRESH(3), .ALM_EMPTY_THRESH(1)) u_d0 (
      .CLK(clk), .RST_N(rst_n), .D(d), .ENQ(enq), .FULL(full_o[0]), .ALM_FULL(afull_o[0]),
      .Q(q_o[0]), .DEQ(deq), .EMPTY(empty_o[0]), .ALM_EMPTY(aempty_o[0]), .LEVEL(lvl0),
      .OVERFLOW(ovf_o[0]), .UNDERFLOW(udf_o[0]), .CLR_ERR(clr));

   sync_level_fifo #(.ADDR_LEN(3), .DATA_WIDTH(8), .FWFT(0), .ALM_FULL_THRESH(6), .ALM_EMPTY_THRESH(2)) u_d1 (
      .CLK(clk), .RST_N(rst_n), .D(d), .ENQ(enq), .FULL(full_o[1]), .ALM_FULL(afull_o[1]),
      .Q(q_o[1]), .DEQ(deq), .EMPTY(empty_o[1]), .ALM_EMPTY(aempty_o[1]), .LEVEL(lvl1),
      .OVERFLOW(ovf_o[1]), .UNDERFLOW(udf_o[1]), .CLR_ERR(clr));

   sync_level_fifo #(.ADDR_LEN(3), .DATA_WIDTH(8), .FWFT(1), .ALM_FULL_THRESH(6), .ALM_EMPTY_THRESH(2)) u_d2 (
      .CLK(clk), .RST_N(rst_n), .D(d), .ENQ(enq), .FULL(full_o[2]), .ALM_FULL(afull_o[2]),
      .Q(q_o[2]), .DEQ(deq), .EMPTY(empty_o[2]), .ALM_EMPTY(aempty_o[2]), .LEVEL(lvl2),
      .OVERFLOW(ovf_o[2]), .UNDERFLOW(udf_o[2]), .CLR_ERR(clr));

   int al [3], fw [3], aft [3], aet [3];
   int n_asrt = 0;
   int n_fail = 0;

   // Reference model: circular word list per configuration plus FWFT visibility.
   logic [7:0] mbuf [3][8];
   int         mhead [3], mcnt [3];
   bit         mvis [3], movf [3], mudf [3];
   logic [7:0] mq [3];

   function automatic int get_lvl(input int k);
      case (k)
         0:       return int'(lvl0);
         1:       return int'(lvl1);
         default: return int'(lvl2);
      endcase
   endfunction

   task automatic chk(input string tag, input int k, input int obs, input int exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h at %0t", tag, k, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mhead[k] = 0; mcnt[k] = 0; mvis[k] = 1'b0;
         movf[k] = 1'b0; mudf[k] = 1'b0; mq[k] = 8'h00;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int cap;
         bit is_full, is_empty, wr, rd;
         cap      = 1 << al[k];
         is_full  = (mcnt[k] == cap);
         is_empty = (fw[k] != 0) ? !mvis[k] : (mcnt[k] == 0);
         wr = enq && !is_full;
         rd = deq && !is_empty;
         if (enq && is_full) movf[k] = 1'b1; else if (clr) movf[k] = 1'b0;
         if (deq && is_empty) mudf[k] = 1'b1; else if (clr) mudf[k] = 1'b0;
         if (rd) begin
            if (fw[k] == 0) mq[k] = mbuf[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % cap;
            mcnt[k]--;
         end
         // A word becomes presentable one cycle after it was written.
         if (fw[k] != 0) mvis[k] = (mcnt[k] > 0);
         if (wr) begin
            mbuf[k][(mhead[k] + mcnt[k]) % cap] = d;
            mcnt[k]++;
         end
         if (fw[k] != 0 && mvis[k]) mq[k] = mbuf[k][mhead[k]];
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         int c;
         c = mcnt[k];
         chk("level", k, get_lvl(k), c);
         chk("full", k, int'(full_o[k]), int'(c == (1 << al[k])));
         chk("empty", k, int'(empty_o[k]), (fw[k] != 0) ? int'(!mvis[k]) : int'(c == 0));
         chk("alm_full", k, int'(afull_o[k]), int'(c >= aft[k]));
         chk("alm_empty", k, int'(aempty_o[k]), int'(c <= aet[k]));
         chk("overflow", k, int'(ovf_o[k]), int'(movf[k]));
         chk("underflow", k, int'(udf_o[k]), int'(mudf[k]));
         if (fw[k] == 0 || mvis[k]) chk("q", k, int'(q_o[k]), int'(mq[k]));
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      al = '{2, 3, 3}; fw = '{0, 0, 1}; aft = '{3, 6, 6}; aet = '{1, 2, 2};
      rst_n = 1'b0; enq = 1'b0; deq = 1'b0; clr = 1'b0; d = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      // Fill the 4-deep instance, overflow it, then drain in order.
      enq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = 8'hA0 + 8'(i);
         cyc();
      end
      chk("fill_full", 0, int'(full_o[0]), 1);
      chk("fill_level", 0, int'(lvl0), 4);
      d = 8'hEE;
      cyc();
      chk("fill_ovf", 0, int'(ovf_o[0]), 1);
      enq = 1'b0; deq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("drain_q", 0, int'(q_o[0]), int'(8'hA0) + i);
      end
      chk("drain_empty", 0, int'(empty_o[0]), 1);
      chk("drain_level", 0, int'(lvl0), 0);
      repeat (2) cyc();
      deq = 1'b0; clr = 1'b1;
      cyc();
      clr = 1'b0;

      // FWFT single word latency.
      enq = 1'b1; d = 8'h55;
      cyc();
      chk("fwft_empty_t", 2, int'(empty_o[2]), 1);
      enq = 1'b0;
      cyc();
      chk("fwft_empty_t1", 2, int'(empty_o[2]), 0);
      chk("fwft_q_t1", 2, int'(q_o[2]), 'h55);
      deq = 1'b1;
      cyc();
      chk("fwft_pop_empty", 2, int'(empty_o[2]), 1);

      // Simultaneous ENQ+DEQ while empty, then while full, then clear vs set.
      enq = 1'b1; d = 8'h11;
      cyc();
      chk("both_empty_level", 0, int'(lvl0), 1);
      chk("both_empty_udf", 0, int'(udf_o[0]), 1);
      deq = 1'b0;
      repeat (3) begin d = 8'($urandom); cyc(); end
      deq = 1'b1; d = 8'h22;
      cyc();
      chk("both_full_level", 0, int'(lvl0), 3);
      chk("both_full_ovf", 0, int'(ovf_o[0]), 1);
      deq = 1'b0; d = 8'h33;
      cyc();
      enq = 1'b0; clr = 1'b1;
      cyc();
      chk("clr_ovf", 0, int'(ovf_o[0]), 0);
      enq = 1'b1;
      cyc();
      chk("clr_vs_set", 0, int'(ovf_o[0]), 1);
      enq = 1'b0; clr = 1'b0; deq = 1'b1;
      repeat (10) cyc();
      deq = 1'b0; clr = 1'b1;
      cyc();
      clr = 1'b0;

      // Steady-state streaming at level 3 across pointer wrap.
      enq = 1'b1;
      repeat (3) begin d = 8'($urandom); cyc(); end
      deq = 1'b1;
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         cyc();
         chk("wrap_level", 1, int'(lvl1), 3);
      end
      enq = 1'b0;
      repeat (4) cyc();
      deq = 1'b0; clr = 1'b1;
      cyc();
      clr = 1'b0;

      // Threshold sweep 0 -> 8 -> 0.
      enq = 1'b1;
      for (int i = 0; i < 8; i++) begin d = 8'($urandom); cyc(); end
      chk("thr_full_af", 1, int'(afull_o[1]), 1);
      enq = 1'b0; deq = 1'b1;
      repeat (8) cyc();
      chk("thr_empty_ae", 1, int'(aempty_o[1]), 1);
      deq = 1'b0; clr = 1'b1;
      cyc();

      // Randomised traffic: fill-biased, then drain-biased.
      for (int i = 0; i < 300; i++) begin
         enq = (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         deq = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         d   = 8'($urandom);
         cyc();
      end
      enq = 1'b0; clr = 1'b0; deq = 1'b1;
      repeat (12) cyc();
      deq = 1'b0; clr = 1'b1;
      cyc();
      clr = 1'b0;

      // Asynchronous reset in the middle of a burst.
      enq = 1'b1;
      repeat (5) begin d = 8'($urandom); cyc(); end
      chk("pre_rst_level", 1, int'(lvl1), 5);
      #3;
      rst_n = 1'b0;
      enq = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      enq = 1'b1; d = 8'h77;
      cyc();
      enq = 1'b0;
      cyc();
      chk("post_rst_fwft_q", 2, int'(q_o[2]), 'h77);
      deq = 1'b1;
      cyc();
      chk("post_rst_q0", 0, int'(q_o[0]), 'h77);
      chk("post_rst_q1", 1, int'(q_o[1]), 'h77);
      deq = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_level_fifo.md
Name: sync_level_fifo

Overview:
- Single-clock, parametrised successor to the team's dual-clock BRAM FIFO, for same-domain buffering, e.g. Boson pixel stream to SD writer.
- All 2**ADDR_LEN entries are usable; the one-slot-wasted full rule is dropped.
- Adds a fill-level output, programmable almost-full/almost-empty flags, and sticky overflow/underflow flags.
- Read mode is selectable: registered read, or first-word-fall-through (FWFT).

Parameters:
ADDR_LEN, 10, log2 depth; MEM_SIZE = 2**ADDR_LEN; legal 2..12
DATA_WIDTH, 32, word width
FWFT, 0, 0 = registered read; 1 = head word presented on Q while EMPTY=0
ALM_FULL_THRESH, MEM_SIZE-4, ALM_FULL asserted when LEVEL >= value; legal 1..MEM_SIZE
ALM_EMPTY_THRESH, 4, ALM_EMPTY asserted when LEVEL <= value; legal 0..MEM_SIZE-1

Ports:
CLK  in  1  sole clock, rising edge
RST_N  in  1  asynchronous active-low reset
D  in  DATA_WIDTH  write data
ENQ  in  1  write request
FULL  out  1  no space; ENQ ignored
ALM_FULL  out  1  LEVEL >= ALM_FULL_THRESH
Q  out  DATA_WIDTH  read data
DEQ  in  1  read request / pop
EMPTY  out  1  no readable word; DEQ ignored
ALM_EMPTY  out  1  LEVEL <= ALM_EMPTY_THRESH
LEVEL  out  ADDR_LEN+1  words stored, 0..MEM_SIZE
OVERFLOW  out  1  sticky: ENQ while FULL
UNDERFLOW  out  1  sticky: DEQ while EMPTY
CLR_ERR  in  1  synchronous clear of OVERFLOW/UNDERFLOW

Behaviour:
- Reset (RST_N low, asynchronous): pointers=0, LEVEL=0, EMPTY=1, ALM_EMPTY=1, FULL=0, ALM_FULL=0, Q=0, OVERFLOW=0, UNDERFLOW=0. Memory contents are not cleared. A reset mid-stream discards all data immediately; the first word written after release is the first word read.
- Pointers are ADDR_LEN+1 bits. Address = low ADDR_LEN bits; wrap is natural modulo 2**(ADDR_LEN+1). full = pointers differ only in MSB.
- Accepted write: wr = ENQ & !FULL. Accepted read: rd = DEQ & !EMPTY. FULL gates ENQ even when DEQ is active in the same cycle.
- LEVEL registered: +1 on wr only, -1 on rd only, unchanged on both or neither.
- FULL, ALM_FULL, ALM_EMPTY registered from next-state LEVEL, so they are exact in the cycle after the edge.
- FWFT=0:
  - EMPTY = (next LEVEL == 0).
  - rd at edge t: Q = mem[head] after edge t. Q holds between reads.
  - Write at edge t: EMPTY=0 after edge t; first DEQ possible at edge t+1.
- FWFT=1:
  - An internal output register plus valid bit feeds Q; EMPTY = !valid.
  - Prefetch fires when (!valid | rd) and memory is non-empty.
  - Write at edge t into an empty FIFO: Q=D and EMPTY=0 after edge t+1.
  - Back-to-back DEQ with memory non-empty: a new word every cycle, no bubble.
  - LEVEL includes the word in the output register.
- Simultaneous ENQ and DEQ:
  - FIFO empty: write accepted, DEQ ignored, UNDERFLOW set.
  - FIFO full: read accepted, ENQ dropped, OVERFLOW set.
  - Otherwise both accepted.
- Error flags: OVERFLOW <= 1 on ENQ & FULL; UNDERFLOW <= 1 on DEQ & EMPTY. Clear on CLR_ERR; a set in the same cycle wins over the clear.
- Read-during-write to the same address cannot occur: the write must complete before the word is counted readable.
- Elaboration-time assertion fails on illegal parameters.

Decomposition:
- Shared package fifo_pkg: clog2 helper, threshold legality check function, read-mode constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1.
- One sub-module sdp_ram:
  - Single clock, simple dual port: one write port, one read port with registered output, read enable.
  - Parameters W_A and W_D; infers block RAM.
  - Top level holds pointers, level, flags, and the FWFT output stage.

Test Plan:
- FWFT=0, ADDR_LEN=2: write 0xA0..0xA3 -> FULL=1 after 4th edge, LEVEL=4. 5th ENQ -> OVERFLOW=1, data unchanged. 4 DEQs -> Q=0xA0..0xA3 in order, EMPTY=1, LEVEL=0.
- FWFT=1: single ENQ of 0x55 into empty FIFO at edge t -> EMPTY=0 and Q=0x55 after edge t+1. DEQ -> EMPTY=1 next cycle.
- Wrap: ADDR_LEN=3, continuous ENQ+DEQ for 40 cycles at LEVEL=3 -> LEVEL stays 3, output sequence is an exact ordered copy of the input, no flag toggles.
- Simultaneous events: ENQ+DEQ while empty -> LEVEL=1, UNDERFLOW=1. ENQ+DEQ while full -> LEVEL=MEM_SIZE-1, OVERFLOW=1. CLR_ERR with a concurrent error -> flag stays 1.
- Thresholds: ALM_FULL_THRESH=6, ALM_EMPTY_THRESH=2, ADDR_LEN=3, fill 0->8->0 -> ALM_EMPTY high for LEVEL 0..2, ALM_FULL high for LEVEL 6..8, each changing on the edge after LEVEL crosses.
- Reset: assert RST_N low mid-burst at LEVEL=5, between clock edges -> outputs go to reset values immediately. After release, write 0x77 and read -> Q=0x77.
